// File: rtl/round_key_adder_pkg.sv
// round_key_adder_pkg: shared sizing defaults and key-index helper for the round-key adder.
package round_key_adder_pkg;
  localparam int NB_DEF = 4;
  localparam int NK_DEF = 8;
  localparam int NR_DEF = NK_DEF + 6;
  localparam int STATE_W_DEF = 32 * NB_DEF;
  localparam int IDX_W = 4;
  // Decryption walks the key schedule backwards from the last round.
  function automatic logic [IDX_W-1:0] key_index(input logic [IDX_W-1:0] round, input logic decrypt, input int nr);
    return decrypt ? IDX_W'(nr) - round : round;
  endfunction
endpackage

// File: rtl/round_key_store.sv
// round_key_store: NR+1 round-key registers with per-entry valid bits and a combinational read port.
module round_key_store
  import round_key_adder_pkg::*;
#(
  parameter int NR = NR_DEF,
  parameter int STATE_W = STATE_W_DEF
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [STATE_W-1:0] wr_data_i,
  input  logic               flush_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [STATE_W-1:0] rd_data_o,
  output logic               rd_valid_o,
  output logic               wr_oob_o
);
  logic [STATE_W-1:0] key_q [NR+1];
  logic [NR:0] valid_q, valid_d;
  logic wr_ok;
  assign wr_oob_o = wr_en_i && (wr_idx_i > IDX_W'(NR));
  assign wr_ok = wr_en_i && !wr_oob_o;
  // Flush wins over a same-cycle write; the stale data left behind is harmless once invalid.
  always_comb begin
    valid_d = valid_q;
    if (wr_ok) valid_d[wr_idx_i] = 1'b1;
    if (flush_i) valid_d = '0;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) valid_q <= '0;
    else valid_q <= valid_d;
  end
  always_ff @(posedge clk_in) begin
    if (wr_ok) key_q[wr_idx_i] <= wr_data_i;
  end
  assign rd_valid_o = (rd_idx_i <= IDX_W'(NR)) && valid_q[rd_idx_i];
  assign rd_data_o = key_q[rd_idx_i];
endmodule

// File: rtl/round_key_adder.sv
// round_key_adder: XORs each accepted state block with its round key through one registered output stage.
module round_key_adder
  import round_key_adder_pkg::*;
#(
  parameter int NB = NB_DEF,
  parameter int NK = NK_DEF,
  parameter int NR = NK + 6,
  localparam int STATE_W = 32 * NB
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               key_wr_en_in,
  input  logic [3:0]         key_wr_idx_in,
  input  logic [STATE_W-1:0] key_wr_data_in,
  input  logic               key_flush_in,
  input  logic               blk_valid_in,
  output logic               blk_ready_out,
  input  logic [STATE_W-1:0] blk_data_in,
  input  logic [3:0]         blk_round_in,
  input  logic               decrypt_in,
  output logic               out_valid_out,
  input  logic               out_ready_in,
  output logic [STATE_W-1:0] out_data_out,
  output logic [3:0]         out_round_out,
  output logic               key_err_out,
  output logic [15:0]        blk_count_out
);
  logic accept, rd_miss, key_ok, wr_oob;
  logic [3:0] rd_idx;
  logic [STATE_W-1:0] key;
  logic out_valid_q, out_valid_d, err_q, err_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic [3:0] round_q, round_d;
  logic [15:0] cnt_q, cnt_d;
  round_key_store #(.NR(NR), .STATE_W(STATE_W)) u_store (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .wr_en_i    (key_wr_en_in),
    .wr_idx_i   (key_wr_idx_in),
    .wr_data_i  (key_wr_data_in),
    .flush_i    (key_flush_in),
    .rd_idx_i   (rd_idx),
    .rd_data_o  (key),
    .rd_valid_o (key_ok),
    .wr_oob_o   (wr_oob)
  );
  assign blk_ready_out = !out_valid_q || out_ready_in;
  assign accept = blk_valid_in && blk_ready_out;
  assign rd_idx = key_index(blk_round_in, decrypt_in, NR);
  assign rd_miss = (blk_round_in > 4'(NR)) || !key_ok;
  // A missing key passes the block through untouched and only raises the sticky error.
  always_comb begin
    out_valid_d = accept ? 1'b1 : out_valid_q && !out_ready_in;
    data_d = accept ? blk_data_in ^ ({STATE_W{!rd_miss}} & key) : data_q;
    round_d = accept ? blk_round_in : round_q;
    cnt_d = cnt_q + 16'(accept);
    err_d = err_q || wr_oob || (accept && rd_miss);
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid_q <= 1'b0;
      data_q <= '0;
      round_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q <= data_d;
      round_q <= round_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign out_valid_out = out_valid_q;
  assign out_data_out = data_q;
  assign out_round_out = round_q;
  assign key_err_out = err_q;
  assign blk_count_out = cnt_q;
endmodule

// File: tb/tb_round_key_adder.sv
// tb_round_key_adder: directed vectors with a scoreboard queue checked by an independent output monitor.
module tb_round_key_adder;
  typedef struct packed {logic [127:0] d; logic [3:0] r;} exp_t;
  logic clk = 0, rst_n = 0;
  logic key_wr_en = 0, key_flush = 0, blk_valid = 0, decrypt = 0, out_ready = 1;
  logic [3:0] key_wr_idx = 0, blk_round = 0;
  logic [127:0] key_wr_data = 0, blk_data = 0;
  logic blk_ready, out_valid, key_err;
  logic [127:0] out_data;
  logic [3:0] out_round;
  logic [15:0] blk_count;
  logic mon_en = 1;
  int total = 0, bad = 0;
  exp_t sbq[$];
  round_key_adder dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .key_wr_en_in(key_wr_en), .key_wr_idx_in(key_wr_idx), .key_wr_data_in(key_wr_data),
    .key_flush_in(key_flush),
    .blk_valid_in(blk_valid), .blk_ready_out(blk_ready), .blk_data_in(blk_data),
    .blk_round_in(blk_round), .decrypt_in(decrypt),
    .out_valid_out(out_valid), .out_ready_in(out_ready), .out_data_out(out_data),
    .out_round_out(out_round), .key_err_out(key_err), .blk_count_out(blk_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got output %h want none", out_data);
      end else begin
        e = sbq.pop_front();
        chk("sb_data", out_data, e.d);
        chk("sb_round", 128'(out_round), 128'(e.r));
      end
    end
  end
  task automatic wr_key(input logic [3:0] idx, input logic [127:0] d);
    key_wr_en = 1; key_wr_idx = idx; key_wr_data = d;
    @(posedge clk); #1;
    key_wr_en = 0;
  endtask
  task automatic send(input logic [127:0] d, input logic [3:0] r, input logic dec, input logic [127:0] exp);
    logic got = 0;
    blk_valid = 1; blk_data = d; blk_round = r; decrypt = dec;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = blk_ready;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 want ready=1 within 20 cycles");
    end
    @(posedge clk);
    if (got) sbq.push_back({exp, r});
    #1 blk_valid = 0;
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_valid"}, 128'(out_valid), 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_round"}, 128'(out_round), 0);
    chk({tag, "_err"}, 128'(key_err), 0);
    chk({tag, "_cnt"}, 128'(blk_count), 0);
    chk({tag, "_ready"}, 128'(blk_ready), 1);
  endtask
  initial begin
    #12 rst_chk("rst0");
    @(posedge clk); #1 rst_n = 1;
    wr_key(0, 128'h000102030405060708090a0b0c0d0e0f);
    send(128'h00112233445566778899aabbccddeeff, 0, 0, 128'h00102030405060708090a0b0c0d0e0f0);
    @(negedge clk);
    chk("lat1_valid", 128'(out_valid), 1);
    chk("lat1_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("lat1_round", 128'(out_round), 0);
    chk("lat1_err", 128'(key_err), 0);
    @(posedge clk); #1;
    for (int i = 0; i <= 14; i++) wr_key(4'(i), 128'(i) * {16{8'h01}});
    send(0, 2, 1, {16{8'h0c}});
    send({16{8'hff}}, 14, 0, {16{8'hf1}});
    send(0, 13, 1, {16{8'h01}});
    @(negedge clk);
    chk("dec_err", 128'(key_err), 0);
    @(posedge clk); #1;
    key_wr_en = 1; key_wr_idx = 5; key_wr_data = {16{8'haa}};
    send(0, 5, 0, {16{8'h05}});
    key_wr_en = 0;
    send(0, 5, 0, {16{8'haa}});
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 0;
    send(0, 1, 0, {16{8'h01}});
    fork
      send(0, 3, 0, {16{8'h03}});
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_ready", 128'(blk_ready), 0);
          chk("bp_hold_data", out_data, {16{8'h01}});
          chk("bp_hold_round", 128'(out_round), 1);
        end
        @(posedge clk); #1 out_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", 128'(blk_ready), 1);
        @(negedge clk);
        chk("bp_second_data", out_data, {16{8'h03}});
        chk("bp_second_valid", 128'(out_valid), 1);
      end
    join
    @(negedge clk);
    chk("pre_oob_err", 128'(key_err), 0);
    @(posedge clk); #1;
    send(128'h0123456789abcdef0123456789abcdef, 15, 0, 128'h0123456789abcdef0123456789abcdef);
    @(negedge clk);
    chk("round_oob_err", 128'(key_err), 1);
    @(posedge clk); #1 rst_n = 0;
    #1 rst_chk("rst1");
    @(posedge clk); #1 rst_n = 1;
    wr_key(15, {16{8'h55}});
    @(negedge clk);
    chk("wr_oob_err", 128'(key_err), 1);
    @(posedge clk); #1;
    wr_key(3, {16{8'h33}});
    send(0, 3, 0, {16{8'h33}});
    @(negedge clk);
    @(posedge clk); #1;
    key_flush = 1; key_wr_en = 1; key_wr_idx = 3; key_wr_data = {16{8'h77}};
    @(posedge clk); #1;
    key_flush = 0; key_wr_en = 0;
    send(128'hdeadbeefdeadbeefdeadbeefdeadbeef, 3, 0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
    @(negedge clk);
    chk("flush_err_sticky", 128'(key_err), 1);
    @(posedge clk); #1 rst_n = 0;
    #1 mon_en = 0;
    @(posedge clk); #1 rst_n = 1;
    blk_valid = 1; blk_data = 0; blk_round = 0; decrypt = 0;
    repeat (65535) @(posedge clk);
    #1 chk("cnt_ffff", 128'(blk_count), 128'hffff);
    repeat (2) @(posedge clk);
    #1 blk_valid = 0;
    chk("cnt_wrap", 128'(blk_count), 1);
    blk_valid = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1 rst_chk("rst_mid");
    blk_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 128'(out_valid), 0);
    end
    chk("sb_drained", 128'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/round_key_adder.md
ROUND_KEY_ADDER -- requirements
Module: round_key_adder

Interface
REQ-001 The parameters SHALL be:
- NB__BLOCK_LENGTH_IN_TEXT, default 4: block words; STATE_W = 32*NB.
- NK__KEY_LENGTH, default 8: key words; legal values 4/6/8.
- NR__ROUNDS, default NK+6: last round index; the key store holds NR+1 entries.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk_in, in, 1: single clock.
- rst_n_in, in, 1: asynchronous active-low reset.
- key_wr_en_in, in, 1: round-key write strobe.
- key_wr_idx_in, in, 4: round-key index to write.
- key_wr_data_in, in, STATE_W: round-key value.
- key_flush_in, in, 1: invalidate all stored keys.
- blk_valid_in, in, 1: input block valid.
- blk_ready_out, out, 1: input block accepted when high with valid.
- blk_data_in, in, STATE_W: state text.
- blk_round_in, in, 4: round number.
- decrypt_in, in, 1: 1 selects reversed key order.
- out_valid_out, out, 1: result valid.
- out_ready_in, in, 1: downstream ready.
- out_data_out, out, STATE_W: state XOR round key.
- out_round_out, out, 4: round number of the result.
- key_err_out, out, 1: sticky error flag.
- blk_count_out, out, 16: count of accepted blocks.

Function
REQ-003 Key store SHALL be NR+1 registers of STATE_W bits, each with a valid bit.
REQ-004 A write with key_wr_idx_in <= NR SHALL store the data and set that entry's valid bit on the next clock edge.
REQ-005 A write with key_wr_idx_in > NR SHALL be ignored and SHALL set key_err_out.
REQ-006 key_flush_in SHALL clear all valid bits in one cycle; flush SHALL take priority over a same-cycle write.
REQ-007 Input and output transfers SHALL occur on (valid & ready) at a rising edge.
REQ-008 Key index SHALL be blk_round_in when decrypt_in=0, and NR-blk_round_in when decrypt_in=1.
REQ-009 On acceptance, out_data_out SHALL be blk_data_in XOR key[index] and out_round_out SHALL be blk_round_in, both registered with latency exactly 1 cycle.
REQ-010 blk_round_in > NR, or a selected entry whose valid bit is clear, SHALL pass blk_data_in unmodified and SHALL set key_err_out; the block SHALL still be accepted and counted.
REQ-011 The output SHALL be a single register stage with blk_ready_out = !out_valid_out | out_ready_in; full throughput SHALL be one block per cycle.
REQ-012 While out_valid_out=1 and out_ready_in=0, out_data_out and out_round_out SHALL hold stable.
REQ-013 A same-cycle key write and block acceptance on the same index SHALL use the old key (read-before-write).
REQ-014 blk_count_out SHALL increment by 1 per accepted block and wrap from 16'hFFFF to 0.
REQ-015 key_err_out SHALL remain set until reset; key_flush_in SHALL NOT clear it.

Reset
REQ-016 rst_n_in low SHALL asynchronously clear: out_valid_out, out_data_out, out_round_out, key_err_out, blk_count_out, and all key valid bits.
REQ-017 Key data registers SHALL NOT need reset.
REQ-018 Reset mid-transfer SHALL discard the in-flight block; no output SHALL appear after reset release.
REQ-019 blk_ready_out SHALL be 1 while in reset and after reset release.

Structure
REQ-020 A shared package SHALL hold the NB/NK/NR defaults, STATE_W, and the derived constant NR = NK+6.
REQ-021 The key store SHALL be one sub-module, round_key_store: write port, flush, combinational read with valid flag.
REQ-022 The handshake, XOR, and counter logic SHALL remain in round_key_adder.

Verification
REQ-023 Load key 0 = 000102030405060708090a0b0c0d0e0f, then send block 00112233445566778899aabbccddeeff with round 0 and decrypt 0 -> next cycle out_data_out = 00102030405060708090a0b0c0d0e0f0, out_round_out = 0, key_err_out = 0.
REQ-024 NK=8: load keys 0..14 with distinct values, decrypt=1, round 2 -> result uses key 12.
REQ-025 Hold out_ready_in=0 for 3 cycles with two blocks offered -> blk_ready_out = 0 after the first block; the first result is held stable; the second block is accepted on the cycle out_ready_in rises.
REQ-026 Write index 15 -> key_err_out = 1; send block round 3 after key_flush_in -> data passes unmodified and key_err_out stays 1.
REQ-027 Accept 65537 blocks -> blk_count_out = 1; assert rst_n_in mid-stream -> all outputs 0 immediately.
